// File: rtl/midori_shared_sequencer.sv
// Sequencer and I/O buffer for an N-share Midori64 threshold round core.
// Accepts shared plaintext plus an unshared key, applies the whitening key to
// share 0 only, steps the external core through ROUNDS x ROUND_CYCLES cycles,
// then registers and holds the shared ciphertext until it is accepted.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid never depends on ready, and ready is a pure function of state.
//
// Optional build macro MIDORI_OUT_ZEROIZE_EN: ciphertext is cleared on the
// output handshake and masked to 0 while out_valid is low, and core_in is
// cleared on entry to HOLD, so no residual shares linger on the buses.
module midori_shared_sequencer #(
    parameter int NSHARES      = 3,
    parameter int ROUNDS       = 16,
    parameter int ROUND_CYCLES = 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [64*NSHARES-1:0]           plaintext,
    input  logic [127:0]                    key,
    output logic                            core_start_sel,
    output logic [$clog2(ROUNDS+1)-1:0]     core_round,
    output logic [63:0]                     core_rk,
    output logic [64*NSHARES-1:0]           core_in,
    input  logic [64*NSHARES-1:0]           core_out,
    output logic                            busy,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [64*NSHARES-1:0]           ciphertext,
    output logic [1:0]                      dbg_state
);

    localparam int SW = 64 * NSHARES;
    localparam int RW = $clog2(ROUNDS + 1);
    localparam int CW = (ROUND_CYCLES > 1) ? $clog2(ROUND_CYCLES) : 1;
    localparam logic [RW-1:0] LAST_ROUND = RW'(ROUNDS - 1);
    localparam logic [CW-1:0] LAST_CYC   = CW'(ROUND_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [127:0]    key_q;
    logic [SW-1:0]   core_in_q;
    logic [SW-1:0]   ct_q;
    logic [RW-1:0]   round_q;
    logic [CW-1:0]   cyc_q;

    logic            accept;
    logic            last_cyc;
    logic            last_round;
    logic            run_done;
    logic            out_hs;
    logic [63:0]     wk_in;
    logic [63:0]     wk_q;

    assign accept     = in_valid && (state_q == IDLE);
    assign last_cyc   = (cyc_q == LAST_CYC);
    assign last_round = (round_q == LAST_ROUND);
    assign run_done   = (state_q == RUN) && last_cyc && last_round;
    assign out_hs     = (state_q == HOLD) && out_ready;

    // Whitening key from the incoming key (for core_in) and the held key (for output).
    assign wk_in = key[127:64] ^ key[63:0];
    assign wk_q  = key_q[127:64] ^ key_q[63:0];

    // Next-state logic for the IDLE -> RUN -> HOLD -> IDLE cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = RUN;
            RUN:     if (run_done) state_d = HOLD;
            HOLD:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath: key/plaintext capture, round/cycle counters, ciphertext capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            key_q     <= '0;
            core_in_q <= '0;
            ct_q      <= '0;
            round_q   <= '0;
            cyc_q     <= '0;
        end else begin
            if (accept) begin
                key_q     <= key;
                core_in_q <= plaintext ^ {{(SW-64){1'b0}}, wk_in};
                round_q   <= '0;
                cyc_q     <= '0;
            end
            if (state_q == RUN) begin
                if (last_cyc) begin
                    cyc_q <= '0;
                    if (!last_round) begin
                        round_q <= round_q + RW'(1);
                    end
                end else begin
                    cyc_q <= cyc_q + CW'(1);
                end
                if (run_done) begin
                    ct_q <= core_out ^ {{(SW-64){1'b0}}, wk_q};
`ifdef MIDORI_OUT_ZEROIZE_EN
                    core_in_q <= '0;
`endif
                end
            end
`ifdef MIDORI_OUT_ZEROIZE_EN
            if (out_hs) begin
                ct_q <= '0;
            end
`endif
        end
    end

    assign in_ready       = (state_q == IDLE);
    assign busy           = (state_q != IDLE);
    assign out_valid      = (state_q == HOLD);
    assign core_start_sel = (state_q == RUN) && (round_q == '0) && (cyc_q == '0);
    assign core_round     = round_q;
    // Even rounds use K0, odd rounds K1; key_q is zero after reset so rk reads 0.
    assign core_rk        = round_q[0] ? key_q[63:0] : key_q[127:64];
    assign core_in        = core_in_q;
    assign dbg_state      = state_q;

`ifdef MIDORI_OUT_ZEROIZE_EN
    assign ciphertext = out_valid ? ct_q : '0;
`else
    assign ciphertext = ct_q;
`endif

endmodule

// File: tb/tb_midori_shared_sequencer.sv
// Self-checking bench for midori_shared_sequencer. A stand-in share-wise
// linear round core closes the loop; a separate unshared reference model
// predicts the XOR of the ciphertext shares. Honors MIDORI_OUT_ZEROIZE_EN.
module tb_midori_shared_sequencer;

    localparam int NS     = 3;
    localparam int ROUNDS = 16;
    localparam int RC     = 2;
    localparam int SW     = 64 * NS;
    localparam int RW     = $clog2(ROUNDS + 1);
    localparam int LAT    = ROUNDS * RC;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [SW-1:0]     plaintext = '0;
    logic [127:0]      key = '0;
    logic              core_start_sel;
    logic [RW-1:0]     core_round;
    logic [63:0]       core_rk;
    logic [SW-1:0]     core_in;
    logic [SW-1:0]     core_out;
    logic              busy;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [SW-1:0]     ciphertext;
    logic [1:0]        dbg_state;

    int                errors = 0;
    int                checks = 0;
    int                cyc_cnt = 0;
    logic [63:0]       exp_q[$];
    logic [63:0]       mon_exp;
    logic [SW-1:0]     core_state;

    // Clock and reset block.
    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    midori_shared_sequencer #(
        .NSHARES(NS), .ROUNDS(ROUNDS), .ROUND_CYCLES(RC)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .plaintext(plaintext), .key(key), .core_start_sel(core_start_sel),
        .core_round(core_round), .core_rk(core_rk), .core_in(core_in),
        .core_out(core_out), .busy(busy), .out_valid(out_valid),
        .out_ready(out_ready), .ciphertext(ciphertext), .dbg_state(dbg_state)
    );

    function automatic logic [63:0] rotl3(input logic [63:0] x);
        return {x[60:0], x[63:61]};
    endfunction

    function automatic logic [63:0] xor_shares(input logic [SW-1:0] s);
        logic [63:0] r = '0;
        for (int i = 0; i < NS; i++) r = r ^ s[64*i +: 64];
        return r;
    endfunction

    // Stand-in core step: every share rotates, share 0 also absorbs rk and round.
    function automatic logic [SW-1:0] core_f(input logic [SW-1:0] x, input logic [RW-1:0] r,
                                             input logic [63:0] rk);
        logic [SW-1:0] y;
        for (int i = 0; i < NS; i++) y[64*i +: 64] = rotl3(x[64*i +: 64]);
        y[63:0] = y[63:0] ^ rk ^ 64'(r);
        return y;
    endfunction

    // Unshared reference: whiten, ROUNDS x RC core steps, whiten again.
    function automatic logic [63:0] ref_enc(input logic [63:0] p, input logic [127:0] k);
        logic [63:0] wk = k[127:64] ^ k[63:0];
        logic [63:0] x = p ^ wk;
        for (int r = 0; r < ROUNDS; r++)
            for (int c = 0; c < RC; c++)
                x = rotl3(x) ^ ((r % 2 == 1) ? k[63:0] : k[127:64]) ^ 64'(r);
        return x ^ wk;
    endfunction

    assign core_out = core_f(core_start_sel ? core_in : core_state, core_round, core_rk);
    always @(posedge clk) begin
        if (reset) core_state <= '0;
        else       core_state <= core_out;
    end

    // Scoreboard: compare ciphertext share XOR at each output handshake.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_unexpected_output got=%h required=no output",
                         xor_shares(ciphertext));
            end else begin
                mon_exp = exp_q.pop_front();
                if (xor_shares(ciphertext) !== mon_exp) begin
                    errors++;
                    $display("FAIL scoreboard_ciphertext got=%h required=%h",
                             xor_shares(ciphertext), mon_exp);
                end
            end
        end
    end

    // Driver: offer one block and wait (bounded) for its acceptance edge.
    task automatic send(input logic [SW-1:0] pt, input logic [127:0] k, output int acc);
        plaintext = pt;
        key = k;
        in_valid = 1'b1;
        acc = -1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(ref_enc(xor_shares(pt), k));
                @(posedge clk);
                #1;
                acc = cyc_cnt;
                break;
            end
        end
        in_valid = 1'b0;
        checks++;
        if (acc < 0) begin
            errors++;
            $display("FAIL send_timeout got=no acceptance required=acceptance");
        end
    endtask

    // Wait (bounded) for out_valid; report cycles since acceptance.
    task automatic wait_out(input int acc, output int lat);
        lat = -1;
        for (int n = 0; n < 400; n++) begin
            if (out_valid === 1'b1) begin
                lat = cyc_cnt - acc;
                break;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (lat < 0) begin
            errors++;
            $display("FAIL out_valid_timeout got=never required=within 400 cycles");
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (dbg_state !== 2'd0 || in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 ||
            core_start_sel !== 1'b0 || core_round !== '0) begin
            errors++;
            $display("FAIL %s_ctrl got st=%0d rdy=%b busy=%b ov=%b sel=%b rnd=%0d required 0,1,0,0,0,0",
                     tag, dbg_state, in_ready, busy, out_valid, core_start_sel, core_round);
        end
        checks++;
        if (core_rk !== 64'h0 || core_in !== '0 || ciphertext !== '0) begin
            errors++;
            $display("FAIL %s_data got rk=%h core_in=%h ct=%h required all zero",
                     tag, core_rk, core_in, ciphertext);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_zero_vector();
        logic [63:0] a = 64'h0123456789abcdef;
        logic [63:0] b = 64'hfedcba9876543210;
        logic [63:0] exp_ct = ref_enc(64'h0, 128'h0);
        int acc, lat;
        out_ready = 1'b1;
        send({a ^ b, b, a}, 128'h0, acc);
        wait_out(acc, lat);
        checks++;
        if (lat !== LAT) begin
            errors++;
            $display("FAIL zero_latency got=%0d required=%0d", lat, LAT);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL zero_after_hs got ov=%b rdy=%b required ov=0 rdy=1", out_valid, in_ready);
        end
        checks++;
`ifdef MIDORI_OUT_ZEROIZE_EN
        if (ciphertext !== '0) begin
            errors++;
            $display("FAIL zeroize_ct got=%h required=0", ciphertext);
        end
`else
        if (xor_shares(ciphertext) !== exp_ct) begin
            errors++;
            $display("FAIL retain_ct got=%h required=%h", xor_shares(ciphertext), exp_ct);
        end
`endif
    endtask

    task automatic test_round_keys();
        logic [127:0] k = 128'h687ded3b3c85b3f35b1009863e2a8cbf;
        logic [63:0]  p = 64'h42c20fd3b586879e;
        logic [63:0]  r1 = {$urandom, $urandom};
        logic [63:0]  r2 = {$urandom, $urandom};
        logic [SW-1:0] pt = {p ^ r1 ^ r2, r2, r1};
        int acc, sel_cnt = 0, rk_bad = 0, rnd_bad = 0, max_rnd = 0, early = 0;
        out_ready = 1'b1;
        send(pt, k, acc);
        checks++;
        if (core_in !== {pt[SW-1:64], pt[63:0] ^ k[127:64] ^ k[63:0]}) begin
            errors++;
            $display("FAIL core_in_whiten got=%h required=%h", core_in,
                     {pt[SW-1:64], pt[63:0] ^ k[127:64] ^ k[63:0]});
        end
        for (int j = 0; j < LAT; j++) begin
            if (core_start_sel === 1'b1) sel_cnt++;
            if (core_round !== RW'(j / RC)) rnd_bad++;
            if (core_rk !== (((j / RC) % 2 == 1) ? k[63:0] : k[127:64])) rk_bad++;
            if (int'(core_round) > max_rnd) max_rnd = int'(core_round);
            if (out_valid !== 1'b0 || busy !== 1'b1) early++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (sel_cnt !== 1) begin
            errors++;
            $display("FAIL start_sel_count got=%0d required=1", sel_cnt);
        end
        checks++;
        if (rnd_bad !== 0 || max_rnd !== ROUNDS - 1) begin
            errors++;
            $display("FAIL round_index bad=%0d max=%0d required bad=0 max=%0d", rnd_bad, max_rnd, ROUNDS - 1);
        end
        checks++;
        if (rk_bad !== 0) begin
            errors++;
            $display("FAIL round_key bad_cycles=%0d required=0", rk_bad);
        end
        checks++;
        if (early !== 0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL std_latency early=%0d ov_at_%0d=%b required early=0 ov=1", early, LAT, out_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_pressure();
        logic [127:0] ka = {$urandom, $urandom, $urandom, $urandom};
        logic [127:0] kb = {$urandom, $urandom, $urandom, $urandom};
        logic [SW-1:0] pa = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        logic [SW-1:0] pb = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        logic [SW-1:0] hold;
        int acc, lat, bad = 0;
        out_ready = 1'b0;
        send(pa, ka, acc);
        wait_out(acc, lat);
        hold = ciphertext;
        checks++;
`ifdef MIDORI_OUT_ZEROIZE_EN
        if (core_in !== '0) begin
            errors++;
            $display("FAIL hold_core_in got=%h required=0", core_in);
        end
`else
        if (core_in !== (pa ^ {{(SW-64){1'b0}}, ka[127:64] ^ ka[63:0]})) begin
            errors++;
            $display("FAIL hold_core_in got=%h required=%h", core_in,
                     pa ^ {{(SW-64){1'b0}}, ka[127:64] ^ ka[63:0]});
        end
`endif
        plaintext = pb;
        key = kb;
        in_valid = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk);
            #1;
            if (ciphertext !== hold || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL backpressure_hold bad_cycles=%0d required=0", bad);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL second_not_early got rdy=%b busy=%b required rdy=1 busy=0", in_ready, busy);
        end
        exp_q.push_back(ref_enc(xor_shares(pb), kb));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        acc = cyc_cnt;
        checks++;
        if (busy !== 1'b1 || core_start_sel !== 1'b1) begin
            errors++;
            $display("FAIL second_accept got busy=%b sel=%b required busy=1 sel=1", busy, core_start_sel);
        end
        wait_out(acc, lat);
        checks++;
        if (lat !== LAT) begin
            errors++;
            $display("FAIL second_latency got=%0d required=%0d", lat, LAT);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_run();
        logic [127:0] k = {$urandom, $urandom, $urandom, $urandom};
        logic [SW-1:0] pt = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        int acc, lat, found = 0;
        out_ready = 1'b1;
        send(pt, k, acc);
        for (int n = 0; n < 100; n++) begin
            if (core_round === RW'(7)) begin
                found = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (found !== 1) begin
            errors++;
            $display("FAIL reach_round7 got=not reached required=reached");
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        check_reset_outputs("midrun_reset");
        reset = 1'b0;
        send(pt ^ {NS{64'h5a5a}}, k, acc);
        wait_out(acc, lat);
        checks++;
        if (lat !== LAT) begin
            errors++;
            $display("FAIL post_reset_latency got=%0d required=%0d", lat, LAT);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        int acc1, acc2;
        out_ready = 1'b1;
        send({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
             {$urandom, $urandom, $urandom, $urandom}, acc1);
        send({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
             {$urandom, $urandom, $urandom, $urandom}, acc2);
        checks++;
        if (acc2 - acc1 !== LAT + 2) begin
            errors++;
            $display("FAIL back_to_back_interval got=%0d required=%0d", acc2 - acc1, LAT + 2);
        end
        for (int n = 0; n < 200 && exp_q.size() != 0; n++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        test_reset();
        test_zero_vector();
        test_round_keys();
        test_back_pressure();
        test_reset_mid_run();
        test_back_to_back();
        repeat (3) @(posedge clk);
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d pending required=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/midori_shared_sequencer.md
# midori_shared_sequencer

Parametrised sequencer and I/O buffer for the N-share Midori64 threshold implementation. It accepts a shared plaintext and an unshared 128-bit key via a valid/ready handshake, derives and applies the whitening key, and drives the round index, start select and round key of an external NSHARES-share round core for ROUNDS rounds of ROUND_CYCLES cycles each. It then registers the shared ciphertext and holds it until the consumer accepts it.

## Interface
- NSHARES, default 3: number of Boolean shares, minimum 2.
- ROUNDS, default 16: round iterations per encryption, range 1..255.
- ROUND_CYCLES, default 1: core latency per round (TI pipeline depth), minimum 1.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  plaintext/key offered.
- in_ready  out  1  sequencer can accept; high only in IDLE.
- plaintext  in  64*NSHARES  shares, share i = bits [64i+63:64i].
- key  in  128  unshared master key; K0 = key[127:64], K1 = key[63:0].
- core_start_sel  out  1  core loads core_in instead of its feedback.
- core_round  out  $clog2(ROUNDS+1)  current round index.
- core_rk  out  64  K0 when core_round is even, K1 when odd.
- core_in  out  64*NSHARES  registered whitened plaintext shares.
- core_out  in  64*NSHARES  core state shares.
- busy  out  1  high in RUN and HOLD.
- out_valid  out  1  ciphertext shares valid.
- out_ready  in  1  consumer accepts ciphertext.
- ciphertext  out  64*NSHARES  registered ciphertext shares.

## Operation
- States: IDLE, RUN, HOLD.
- IDLE:
  - in_ready = 1.
  - On in_valid: capture key.
  - Capture core_in = plaintext with share 0 XORed with WK = K0 ^ K1; other shares pass unchanged.
  - Go to RUN with round = 0 and cyc = 0.
- RUN:
  - cyc counts 0..ROUND_CYCLES-1.
  - At cyc = ROUND_CYCLES-1 in round ROUNDS-1, capture core_out into ciphertext with share 0 XORed with WK, then go to HOLD.
  - Otherwise, at cyc = ROUND_CYCLES-1, round increments and cyc returns to 0.
- core_start_sel is high only in RUN, round 0, cyc 0.
- HOLD:
  - out_valid = 1.
  - On out_ready, go to IDLE.
  - The first next input is accepted no earlier than the following cycle.
- The captured key and core_in are stable for the whole RUN. in_valid is ignored outside IDLE.
- Key and whitening are never shared. Only share 0 is modified; shares are never recombined inside this block.
- Reset, including mid-RUN or mid-HOLD:
  - Next state is IDLE and the operation is aborted with no output.
  - in_ready = 1, busy = 0, out_valid = 0, core_start_sel = 0, core_round = 0.
  - core_rk, core_in and ciphertext are all 0; key register is 0.

## Timing
- Acceptance at edge T (in_valid & in_ready). RUN begins at cycle T+1, with core_start_sel high during T+1.
- out_valid rises after edge T + ROUNDS*ROUND_CYCLES. With the defaults it is 16 cycles after acceptance.
- Back-to-back throughput is one block per ROUNDS*ROUND_CYCLES + 2 cycles when out_ready is held high.
- out_valid with out_ready low: ciphertext and out_valid remain stable indefinitely.
- ROUND_CYCLES = 1: every RUN cycle advances the round.

## Configuration
- MIDORI_OUT_ZEROIZE_EN defined:
  - ciphertext registers clear to 0 on the out handshake edge and read 0 whenever out_valid = 0.
  - core_in clears to 0 on entry to HOLD.
  - This prevents residual shares from lingering on the bus.
- Not defined: ciphertext and core_in retain their last values until overwritten.

## Test plan
- Zero vector, NSHARES=3, ROUND_CYCLES=1, real core:
  - Stimulus: key = 0, plaintext shares A, B, A^B with A = 0123456789abcdef, B = fedcba9876543210.
  - Required: XOR of ciphertext shares = 3c9cceda2bbd449a; out_valid 16 cycles after acceptance.
- Standard vector, NSHARES=4, ROUND_CYCLES=2:
  - Stimulus: key = 687ded3b3c85b3f35b1009863e2a8cbf, plaintext XOR = 42c20fd3b586879e.
  - Required: output XOR = 66bcdc6270d901cd; out_valid 32 cycles after acceptance.
- Back-pressure:
  - Stimulus: hold out_ready = 0 for 20 cycles, pulse in_valid during HOLD.
  - Required: ciphertext stable; in_ready = 0; second input not accepted until the cycle after the handshake.
- Reset mid-RUN:
  - Stimulus: assert reset at round 7.
  - Required: next cycle in IDLE with all outputs at reset values; a new encryption then produces the correct ciphertext.
- Round key sequencing:
  - Required: core_rk alternates K0/K1 per round.
  - Required: core_start_sel high for exactly one cycle per block.
  - Required: core_round reaches ROUNDS-1 and never ROUNDS.
- MIDORI_OUT_ZEROIZE_EN:
  - Required: ciphertext reads 0 one cycle after the out handshake.
  - Without the macro, ciphertext retains its previous value.
